// File: rtl/i2s_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver_if
//  Description : Pin/result bundle for the I2S receiver. The master side is
//                whatever drives the codec pins and consumes the words; the
//                slave side is the receiver itself.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    Enable      master->slave  1 = receive, 0 = hold in SYNC
//    SCLK        master->slave  I2S bit clock (asynchronous to MCLK)
//    LRCLK       master->slave  I2S word select, 0 = left, 1 = right
//    SD          master->slave  I2S serial data, MSB first
//    Left_Data   slave->master  last completed left word
//    Right_Data  slave->master  last completed right word
//    Valid       slave->master  one-MCLK strobe, both words updated together
//    Frame_Error slave->master  one-MCLK strobe on a malformed half-frame
// ============================================================================
interface i2s_receiver_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Enable;
  logic             SCLK;
  logic             LRCLK;
  logic             SD;
  logic [WIDTH-1:0] Left_Data;
  logic [WIDTH-1:0] Right_Data;
  logic             Valid;
  logic             Frame_Error;

  modport master (
    output Enable, SCLK, LRCLK, SD,
    input  Left_Data, Right_Data, Valid, Frame_Error
  );

  modport slave (
    input  Enable, SCLK, LRCLK, SD,
    output Left_Data, Right_Data, Valid, Frame_Error
  );
endinterface
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver
//  Description : Samples an external I2S stream in the MCLK domain and
//                deserializes each stereo frame into left/right words of
//                WIDTH bits, presented together with a one-cycle Valid.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    MCLK   in   system clock, all logic on posedge
//    Reset  in   asynchronous active-high reset, clears all state/outputs
//    bus    slave modport of i2s_receiver_if (pins in, words/strobes out)
//  Build option
//    I2S_RX_FRAME_CHECK_EN : when defined, Frame_Error pulses when a finished
//                            half-frame did not carry exactly WIDTH bits.
//                            When undefined, Frame_Error is tied to 0.
// ============================================================================
module i2s_receiver #(
  parameter int unsigned WIDTH = 16
) (
  input  wire logic     MCLK,
  input  wire logic     Reset,
  i2s_receiver_if.slave bus
);

  // Bit counter saturates at WIDTH+1 so over-long words remain detectable.
  localparam int unsigned           c_CNT_W   = $clog2(WIDTH + 2);
  localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [1:0]         r_sclk_sync;
  logic [1:0]         r_lr_sync;
  logic [1:0]         r_sd_sync;
  logic               r_sclk_dly;
  logic               r_lr_prev;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_left_hold;
  logic [WIDTH-1:0]   r_left_data;
  logic [WIDTH-1:0]   r_right_data;
  logic               r_valid;

  logic               w_rise;
  logic               w_lr;
  logic               w_sd;
  logic               w_boundary;
  logic               w_latch_left;
  logic               w_deliver;
  logic [WIDTH-1:0]   w_shift_next;

  // All three pins get the same synchronizer depth so LRCLK/SD stay aligned
  // with the SCLK edge they were stable across.
  always_ff @(posedge MCLK or posedge Reset) begin
    if (Reset) begin
      r_sclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sd_sync   <= '0;
      r_sclk_dly  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], bus.SCLK};
      r_lr_sync   <= {r_lr_sync[0],   bus.LRCLK};
      r_sd_sync   <= {r_sd_sync[0],   bus.SD};
      r_sclk_dly  <= r_sclk_sync[1];
    end
  end

  assign w_rise     = r_sclk_sync[1] & ~r_sclk_dly;
  assign w_lr       = r_lr_sync[1];
  assign w_sd       = r_sd_sync[1];
  // A word-select change at a rise marks the LSB of the channel in r_lr_prev.
  assign w_boundary = w_rise & (w_lr ^ r_lr_prev);

  // Current shift register with this rise's bit placed at WIDTH-1-count.
  // Counts of WIDTH and above match no index, so surplus bits drop out.
  always_comb begin
    w_shift_next = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_bit_cnt == c_CNT_W'(WIDTH - 1 - i)) begin
        w_shift_next[i] = w_sd;
      end
    end
  end

  // FSM state register
  always_ff @(posedge MCLK or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state / strobes
  always_comb begin
    w_state_next = r_state;
    w_latch_left = 1'b0;
    w_deliver    = 1'b0;
    if (!bus.Enable) begin
      w_state_next = ST_SYNC;
    end else begin
      case (r_state)
        ST_SYNC: begin
          // Only a right->left change gives a clean frame start.
          if (w_boundary && r_lr_prev && !w_lr) begin
            w_state_next = ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (w_boundary && !r_lr_prev) begin
            w_latch_left = 1'b1;
            w_state_next = ST_RIGHT;
          end
        end
        ST_RIGHT: begin
          if (w_boundary && r_lr_prev) begin
            w_deliver    = 1'b1;
            w_state_next = ST_LEFT;
          end
        end
        default: w_state_next = ST_SYNC;
      endcase
    end
  end

  // Datapath: bit capture, word latching and output registers
  always_ff @(posedge MCLK or posedge Reset) begin
    if (Reset) begin
      r_lr_prev    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_left_data  <= '0;
      r_right_data <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= w_deliver;
      if (w_rise) begin
        r_lr_prev <= w_lr;
        if (w_boundary) begin
          // Boundary bit is consumed via w_shift_next below; start fresh.
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shift <= w_shift_next;
          if (r_bit_cnt != c_CNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
      end
      if (w_latch_left) begin
        r_left_hold <= w_shift_next;
      end
      if (w_deliver) begin
        r_left_data  <= r_left_hold;
        r_right_data <= w_shift_next;
      end
    end
  end

  assign bus.Left_Data  = r_left_data;
  assign bus.Right_Data = r_right_data;
  assign bus.Valid      = r_valid;

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  logic r_frame_err;
  logic w_word_end;

  // The boundary bit itself is bit number r_bit_cnt+1 of the word.
  assign w_word_end = w_latch_left | w_deliver;

  always_ff @(posedge MCLK or posedge Reset) begin
    if (Reset) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_word_end & (r_bit_cnt != c_CNT_LAST);
    end
  end

  assign bus.Frame_Error = r_frame_err;
`else
  assign bus.Frame_Error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/i2s_receiver.md
# i2s_receiver

Audio-input counterpart of the I2S transmit path. It samples an externally driven I2S stream (SCLK, LRCLK, SD) in the MCLK domain and deserializes each stereo frame into left and right words of WIDTH bits. It presents each completed frame with a one-cycle Valid strobe. It sits between the board audio-codec ADC pins and the game's sound logic.

## Interface
- WIDTH, 16, bits per channel word, MSB first.
- MCLK  in  1  system clock (25 MHz); all logic on posedge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs.
- Enable  in  1  1 = receive, 0 = hold in SYNC, no strobes.
- SCLK  in  1  I2S bit clock from codec (asynchronous to MCLK).
- LRCLK  in  1  I2S word select: 0 = left, 1 = right.
- SD  in  1  I2S serial data.
- Left_Data  out  WIDTH  last completed left word.
- Right_Data  out  WIDTH  last completed right word.
- Valid  out  1  one-MCLK pulse; Left_Data/Right_Data updated together.
- Frame_Error  out  1  one-MCLK pulse on a malformed half-frame (see Configuration).

## Operation
- SCLK, LRCLK and SD each pass through a 2-flop synchronizer of identical depth. A delayed copy of synced SCLK gives Sclk_Rise = synced & ~delayed.
- On each Sclk_Rise the block samples SD and LRCLK, compares LRCLK with its value at the previous Sclk_Rise (Lr_Prev), then updates Lr_Prev.
- Standard I2S alignment applies. If LRCLK differs from Lr_Prev at a rise, the bit sampled at that rise is the LSB of the channel named by Lr_Prev, which ends that word. The next rise carries the MSB of the new channel.
- Bit placement: Bit_Cnt counts bits in the current half-frame and saturates at WIDTH+1.
  - While Bit_Cnt < WIDTH, SD is written to Shift[WIDTH-1-Bit_Cnt].
  - Extra bits are ignored.
  - Shift is cleared at word start, so short words are left-aligned with zero LSBs.
- States:
  - SYNC: reset state. Waits for a boundary with Lr_Prev=1 and LRCLK=0 (end of a right word). Discards data and goes to LEFT.
  - LEFT: collects bits. On a boundary with Lr_Prev=0, latches Shift (including the boundary bit) into Left_Hold and goes to RIGHT.
  - RIGHT: collects bits. On a boundary with Lr_Prev=1, copies Left_Hold to Left_Data and Shift to Right_Data, pulses Valid, and goes to LEFT.
- The first Valid after SYNC therefore reflects one complete left+right pair; no partial frame is ever output.
- Enable=0: state is forced to SYNC next cycle. Left_Data/Right_Data hold their values and Valid stays 0. Re-enabling resynchronizes from scratch.
- Reset asserted mid-frame: immediate return to SYNC; all outputs go to 0.

## Timing
- Reset values: Left_Data=0, Right_Data=0, Valid=0, Frame_Error=0, state=SYNC, Bit_Cnt=0, Lr_Prev=0, synchronizers=0.
- Latency: Valid is high in the cycle after the 3rd MCLK posedge following the SCLK pin rise that carries the right-word LSB. Frame_Error has the same latency.
- Valid is never asserted on two consecutive cycles; at most one per frame.
- SCLK high and low phases must each be at least 2 MCLK periods (SCLK ≤ MCLK/4). LRCLK and SD must be stable across SCLK rise, per the I2S spec.
- A single Sclk_Rise that is also a boundary both writes the boundary bit and ends the word in the same cycle.

## Configuration
- I2S_RX_FRAME_CHECK_EN defined: at each boundary outside SYNC, if the finishing word had Bit_Cnt+1 ≠ WIDTH, Frame_Error pulses one cycle. The word is still latched and delivered normally.
- Not defined: Frame_Error tied to 0 and no compare logic is built; data path unchanged.

## Test plan
- Reset/idle: Reset=1, then release with SCLK toggling and LRCLK=0 constant -> all outputs 0, state stays SYNC, no Valid.
- Nominal frame: WIDTH=16, SCLK=MCLK/20, send pre-sync frame, then L=16'hA5C3, R=16'h0F0F -> exactly one Valid; Left_Data=A5C3, Right_Data=0F0F; next frame L=8000, R=0001 updates both on the next Valid.
- Long words: 20 SCLKs per half-frame, L=A5C3 followed by 4 junk bits -> Left_Data=A5C3; Frame_Error pulses with macro, 0 without.
- Short words: 12 SCLKs per half-frame, L bits 0xFFF -> Left_Data=FFF0; Frame_Error pulse only with macro.
- Enable drop: deassert Enable mid-right-word, reassert -> no Valid for the broken frame; outputs hold old values; first Valid follows the first complete L/R pair after a right->left boundary.
- Reset mid-frame: assert Reset during the left word of a valid stream -> outputs 0 in the same cycle; after release, the next Valid occurs only after a full resync frame.
